// File: rtl/bellek_hakemi_pkg.sv
// Shared types and constants for the bellek_hakemi memory-port arbiter.
// - hkm_durum_t  : arbiter FSM state encoding (2-bit)
// - HKM_MASKE_OKU: byte mask value that marks a read access
package bellek_hakemi_pkg;

  typedef enum logic [1:0] {
    HKM_BOS   = 2'd0,
    HKM_GETIR = 2'd1,
    HKM_BIB   = 2'd2
  } hkm_durum_t;

  localparam logic [3:0] HKM_MASKE_OKU = 4'b0000;

endpackage

// File: rtl/bellek_hakemi_oncelik.sv
// Combinational winner select for the shared memory port.
// Ports:
//   i_getir_sec  : fetch side is requesting
//   i_bib_sec    : load/store side is requesting
//   i_aclik_dolu : fetch has lost the maximum allowed number of times in a row
//   o_getir_kazan: fetch wins this arbitration
//   o_bib_kazan  : load/store wins this arbitration
// At most one output is high; both are low when nobody requests.
module bellek_hakemi_oncelik (
  input  logic i_getir_sec,
  input  logic i_bib_sec,
  input  logic i_aclik_dolu,
  output logic o_getir_kazan,
  output logic o_bib_kazan
);

  // Data side normally has priority; a starved fetch overrides it.
  assign o_bib_kazan   = i_bib_sec & ~(i_getir_sec & i_aclik_dolu);
  assign o_getir_kazan = i_getir_sec & (~i_bib_sec | i_aclik_dolu);

endmodule

// File: rtl/bellek_hakemi.sv
// Shares one memory port between instruction fetch (getir) and the
// load/store unit (bib). The winning request is latched into registered
// bellek_* outputs, the response is routed back to its owner, fetch is
// protected against starvation and each access has a cycle timeout.
// Ports:
//   clk_i, rst_i                      : clock, asynchronous active-high reset
//   getir_sec_i/getir_adr_i           : fetch request (level) and address
//   getir_veri_o/getir_durdur_o       : fetched word, fetch stall
//   bib_sec_i/adr/veri/maske_i        : load/store request, address, store data, byte mask
//   bib_veri_o/bib_durdur_o           : load data, load/store stall
//   bellek_sec/adr/veri/maske_o       : registered memory request
//   bellek_veri_i/bellek_gecerli_i    : memory read data, one-cycle response pulse
//   hata_o                            : sticky timeout flag
//   durum_o                           : current FSM state (debug)
//
// Handshake: a requester holds *_sec_i high with stable request fields; the
// access is finished in the cycle where sec_i is high and durdur_o is low.
// durdur_o only drops for the owner in its response (or abort) cycle.
module bellek_hakemi
  import bellek_hakemi_pkg::*;
#(
  parameter int ADR_BIT     = 32,
  parameter int VERI_BIT    = 32,
  parameter int ACLIK_ESIK  = 4,
  parameter int ZAMAN_ASIMI = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                getir_sec_i,
  input  logic [ADR_BIT-1:0]  getir_adr_i,
  output logic [VERI_BIT-1:0] getir_veri_o,
  output logic                getir_durdur_o,
  input  logic                bib_sec_i,
  input  logic [ADR_BIT-1:0]  bib_adr_i,
  input  logic [VERI_BIT-1:0] bib_veri_i,
  input  logic [3:0]          bib_maske_i,
  output logic [VERI_BIT-1:0] bib_veri_o,
  output logic                bib_durdur_o,
  output logic                bellek_sec_o,
  output logic [ADR_BIT-1:0]  bellek_adr_o,
  output logic [VERI_BIT-1:0] bellek_veri_o,
  output logic [3:0]          bellek_maske_o,
  input  logic [VERI_BIT-1:0] bellek_veri_i,
  input  logic                bellek_gecerli_i,
  output logic                hata_o,
  output hkm_durum_t          durum_o
);

  localparam logic [3:0] L_ESIK = 4'(ACLIK_ESIK);
  // Abort fires in the last allowed wait cycle, so the request is visible
  // for exactly ZAMAN_ASIMI cycles.
  localparam logic [7:0] L_SON  = 8'(ZAMAN_ASIMI - 1);

  hkm_durum_t          r_durum;
  hkm_durum_t          w_durum_sonraki;
  logic [3:0]          r_aclik;
  logic [7:0]          r_sayac;
  logic                r_sec;
  logic [ADR_BIT-1:0]  r_adr;
  logic [VERI_BIT-1:0] r_veri;
  logic [3:0]          r_maske;
  logic                r_hata;

  logic w_getir_kazan;
  logic w_bib_kazan;
  logic w_aclik_dolu;
  logic w_bos;
  logic w_zaman_doldu;
  logic w_bitti;
  logic w_getir_sahip;
  logic w_bib_sahip;

  assign w_aclik_dolu  = (r_aclik == L_ESIK);
  assign w_bos         = (r_durum == HKM_BOS);
  assign w_getir_sahip = (r_durum == HKM_GETIR);
  assign w_bib_sahip   = (r_durum == HKM_BIB);
  assign w_zaman_doldu = !w_bos && !bellek_gecerli_i && (r_sayac == L_SON);
  assign w_bitti       = !w_bos && (bellek_gecerli_i || w_zaman_doldu);

  bellek_hakemi_oncelik u_oncelik (
    .i_getir_sec  (getir_sec_i),
    .i_bib_sec    (bib_sec_i),
    .i_aclik_dolu (w_aclik_dolu),
    .o_getir_kazan(w_getir_kazan),
    .o_bib_kazan  (w_bib_kazan)
  );

  // Next-state logic. Arbitration only happens in BOS, so the response
  // cycle never overlaps with a new grant.
  always_comb begin
    w_durum_sonraki = r_durum;
    case (r_durum)
      HKM_BOS: begin
        if (w_bib_kazan)        w_durum_sonraki = HKM_BIB;
        else if (w_getir_kazan) w_durum_sonraki = HKM_GETIR;
      end
      HKM_GETIR, HKM_BIB: begin
        if (w_bitti) w_durum_sonraki = HKM_BOS;
      end
      default: w_durum_sonraki = HKM_BOS;
    endcase
  end

  // Response routing and stall generation. On abort the owner sees data 0.
  always_comb begin
    getir_veri_o   = '0;
    bib_veri_o     = '0;
    if (w_getir_sahip && bellek_gecerli_i) getir_veri_o = bellek_veri_i;
    if (w_bib_sahip && bellek_gecerli_i)   bib_veri_o   = bellek_veri_i;
    getir_durdur_o = getir_sec_i & ~(w_getir_sahip & w_bitti);
    bib_durdur_o   = bib_sec_i & ~(w_bib_sahip & w_bitti);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_durum <= HKM_BOS;
      r_aclik <= '0;
      r_sayac <= '0;
      r_sec   <= 1'b0;
      r_adr   <= '0;
      r_veri  <= '0;
      r_maske <= '0;
      r_hata  <= 1'b0;
    end else begin
      r_durum <= w_durum_sonraki;

      // Consecutive fetch losses; only an actual lost arbitration counts.
      if (!getir_sec_i || (w_bos && w_getir_kazan)) begin
        r_aclik <= '0;
      end else if (w_bos && w_bib_kazan && !w_aclik_dolu) begin
        r_aclik <= r_aclik + 4'd1;
      end

      if (w_bos) begin
        if (w_bib_kazan) begin
          r_sec   <= 1'b1;
          r_adr   <= bib_adr_i;
          r_veri  <= bib_veri_i;
          r_maske <= bib_maske_i;
          r_sayac <= '0;
        end else if (w_getir_kazan) begin
          r_sec   <= 1'b1;
          r_adr   <= getir_adr_i;
          r_veri  <= '0;
          r_maske <= HKM_MASKE_OKU;
          r_sayac <= '0;
        end
      end else if (w_bitti) begin
        r_sec <= 1'b0;
        if (w_zaman_doldu) r_hata <= 1'b1;
      end else begin
        r_sayac <= r_sayac + 8'd1;
      end
    end
  end

  assign bellek_sec_o   = r_sec;
  assign bellek_adr_o   = r_adr;
  assign bellek_veri_o  = r_veri;
  assign bellek_maske_o = r_maske;
  assign hata_o         = r_hata;
  assign durum_o        = r_durum;

endmodule

// File: tb/tb_bellek_hakemi.sv
// Directed bench for bellek_hakemi with a transaction-level reference model
// checked on every falling clock edge, plus literal expectations per scenario.
module tb_bellek_hakemi;
  import bellek_hakemi_pkg::*;

  localparam int ESIK = 4;
  localparam int ZA   = 8;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        getir_sec_i;
  logic [31:0] getir_adr_i;
  logic [31:0] getir_veri_o;
  logic        getir_durdur_o;
  logic        bib_sec_i;
  logic [31:0] bib_adr_i;
  logic [31:0] bib_veri_i;
  logic [3:0]  bib_maske_i;
  logic [31:0] bib_veri_o;
  logic        bib_durdur_o;
  logic        bellek_sec_o;
  logic [31:0] bellek_adr_o;
  logic [31:0] bellek_veri_o;
  logic [3:0]  bellek_maske_o;
  logic [31:0] bellek_veri_i;
  logic        bellek_gecerli_i;
  logic        hata_o;
  hkm_durum_t  durum_o;

  bellek_hakemi #(
    .ADR_BIT(32), .VERI_BIT(32), .ACLIK_ESIK(ESIK), .ZAMAN_ASIMI(ZA)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .getir_sec_i(getir_sec_i), .getir_adr_i(getir_adr_i),
    .getir_veri_o(getir_veri_o), .getir_durdur_o(getir_durdur_o),
    .bib_sec_i(bib_sec_i), .bib_adr_i(bib_adr_i), .bib_veri_i(bib_veri_i),
    .bib_maske_i(bib_maske_i), .bib_veri_o(bib_veri_o), .bib_durdur_o(bib_durdur_o),
    .bellek_sec_o(bellek_sec_o), .bellek_adr_o(bellek_adr_o),
    .bellek_veri_o(bellek_veri_o), .bellek_maske_o(bellek_maske_o),
    .bellek_veri_i(bellek_veri_i), .bellek_gecerli_i(bellek_gecerli_i),
    .hata_o(hata_o), .durum_o(durum_o)
  );

  // ---------------- scoreboard ----------------
  int n_vec;
  int n_err;
  logic [31:0] exp_q[$];   // expected bellek_adr_o at each new grant

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state: who owns the port, how long it has waited,
  // what was latched, how many times fetch has lost in a row.
  int          m_owner;   // 0 idle, 1 fetch, 2 load/store
  int          m_waited;
  int          m_losses;
  logic        m_hata;
  logic [31:0] m_adr;
  logic [31:0] m_veri;
  logic [3:0]  m_maske;
  logic        prev_sec;

  // Observation counters for the literal checks
  int          getir_ack_cnt;
  logic [31:0] getir_ack_veri;
  int          bib_ack_cnt;
  logic [31:0] bib_ack_veri;

  always @(negedge clk) begin
    logic done, abort, fin;
    logic [31:0] e_gv, e_bv, g;
    hkm_durum_t e_st;
    if (rst) begin
      m_owner = 0; m_waited = 0; m_losses = 0; m_hata = 1'b0;
      m_adr = '0; m_veri = '0; m_maske = '0; prev_sec = 1'b0;
      chk("rst_sec", bellek_sec_o, 0);
      chk("rst_adr", bellek_adr_o, 0);
      chk("rst_hata", hata_o, 0);
      chk("rst_durum", durum_o, HKM_BOS);
    end else begin
      done  = (m_owner != 0) && bellek_gecerli_i;
      abort = (m_owner != 0) && !bellek_gecerli_i && (m_waited + 1 == ZA);
      fin   = done || abort;
      e_gv  = (m_owner == 1 && done) ? bellek_veri_i : 32'h0;
      e_bv  = (m_owner == 2 && done) ? bellek_veri_i : 32'h0;
      e_st  = (m_owner == 0) ? HKM_BOS : (m_owner == 1) ? HKM_GETIR : HKM_BIB;

      chk("sec", bellek_sec_o, m_owner != 0);
      chk("adr", bellek_adr_o, m_adr);
      chk("wdata", bellek_veri_o, m_veri);
      chk("mask", bellek_maske_o, m_maske);
      chk("getir_durdur", getir_durdur_o, getir_sec_i && !(m_owner == 1 && fin));
      chk("bib_durdur", bib_durdur_o, bib_sec_i && !(m_owner == 2 && fin));
      chk("getir_veri", getir_veri_o, e_gv);
      chk("bib_veri", bib_veri_o, e_bv);
      chk("hata", hata_o, m_hata);
      chk("durum", durum_o, e_st);

      if (bellek_sec_o && !prev_sec) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_grant: got adr %0h expected none", bellek_adr_o);
        end else begin
          g = exp_q.pop_front();
          chk("grant_adr", bellek_adr_o, g);
        end
      end
      prev_sec = bellek_sec_o;

      if (getir_sec_i && !getir_durdur_o) begin getir_ack_cnt++; getir_ack_veri = getir_veri_o; end
      if (bib_sec_i && !bib_durdur_o) begin bib_ack_cnt++; bib_ack_veri = bib_veri_o; end

      // advance model to the next cycle
      if (m_owner != 0) begin
        if (fin) begin
          m_owner = 0;
          if (abort) m_hata = 1'b1;
        end else begin
          m_waited++;
        end
        if (!getir_sec_i) m_losses = 0;
      end else if (bib_sec_i && (!getir_sec_i || m_losses < ESIK)) begin
        m_owner = 2; m_waited = 0;
        m_adr = bib_adr_i; m_veri = bib_veri_i; m_maske = bib_maske_i;
        m_losses = getir_sec_i ? ((m_losses + 1 > ESIK) ? ESIK : m_losses + 1) : 0;
      end else if (getir_sec_i) begin
        m_owner = 1; m_waited = 0;
        m_adr = getir_adr_i; m_veri = '0; m_maske = 4'b0000;
        m_losses = 0;
      end else begin
        m_losses = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sec();
    int k;
    k = 0;
    while (!bellek_sec_o && k < 20) begin
      tick();
      k++;
    end
    if (!bellek_sec_o) begin
      n_vec++; n_err++;
      $display("FAIL wait_sec: got no bellek_sec_o expected one within 20 cycles");
    end
  endtask

  task automatic pulse(input logic [31:0] d);
    bellek_gecerli_i = 1'b1;
    bellek_veri_i    = d;
    tick();
    bellek_gecerli_i = 1'b0;
    bellek_veri_i    = 32'hDEAD_0000;
  endtask

  task automatic serve(input int gecikme, input logic [31:0] d);
    wait_sec();
    repeat (gecikme) tick();
    pulse(d);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [31:0] g_adr [10];
    n_vec = 0; n_err = 0;
    getir_ack_cnt = 0; bib_ack_cnt = 0;
    getir_ack_veri = '0; bib_ack_veri = '0;
    rst = 1'b0;
    getir_sec_i = 0; getir_adr_i = 0;
    bib_sec_i = 0; bib_adr_i = 0; bib_veri_i = 0; bib_maske_i = 0;
    bellek_veri_i = 32'hDEAD_0000; bellek_gecerli_i = 0;
    #1 rst = 1'b1;
    repeat (3) tick();
    chk("rst_durdur_g", getir_durdur_o, 0);
    chk("rst_durdur_b", bib_durdur_o, 0);
    rst = 1'b0;
    tick();

    // 1: fetch alone, memory answers one cycle after the request appears
    getir_ack_cnt = 0;
    getir_sec_i = 1; getir_adr_i = 32'h100;
    exp_q.push_back(32'h100);
    serve(1, 32'hCAFE_BABE);
    getir_sec_i = 0;
    tick();
    chk("fetch_ack_cnt", getir_ack_cnt, 1);
    chk("fetch_veri", getir_ack_veri, 32'hCAFE_BABE);

    // stray response while idle must be ignored
    pulse(32'h5555_5555);
    chk("idle_gecerli_sec", bellek_sec_o, 0);
    tick();

    // 2: both request continuously; bib x4 then getir, twice
    g_adr = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h300,
              32'h200, 32'h200, 32'h200, 32'h200, 32'h300};
    for (int i = 0; i < 10; i++) exp_q.push_back(g_adr[i]);
    bib_sec_i = 1; bib_adr_i = 32'h200; bib_veri_i = 0; bib_maske_i = 4'b0000;
    getir_sec_i = 1; getir_adr_i = 32'h300;
    for (int i = 0; i < 10; i++) serve(0, 32'h1000 + i);
    bib_sec_i = 0; getir_sec_i = 0;
    tick();
    chk("contention_q_drained", exp_q.size(), 0);

    // 3: store with byte mask, request fields stable until the response
    bib_sec_i = 1; bib_adr_i = 32'h40; bib_veri_i = 32'h00AB_0000; bib_maske_i = 4'b0100;
    exp_q.push_back(32'h40);
    wait_sec();
    chk("store_mask", bellek_maske_o, 4'b0100);
    chk("store_wdata", bellek_veri_o, 32'h00AB_0000);
    bib_veri_i = 32'hFFFF_FFFF; bib_maske_i = 4'b1111;   // must not leak
    repeat (3) tick();
    chk("store_mask_held", bellek_maske_o, 4'b0100);
    chk("store_wdata_held", bellek_veri_o, 32'h00AB_0000);
    pulse(32'h0);
    bib_sec_i = 0; bib_veri_i = 0; bib_maske_i = 0;
    tick();

    // 4: timeout with no response
    bib_ack_cnt = 0; bib_ack_veri = 32'hFFFF_FFFF;
    bib_sec_i = 1; bib_adr_i = 32'h80;
    exp_q.push_back(32'h80);
    wait_sec();
    n = 1;
    while (bellek_sec_o && n < 30) begin
      tick();
      if (bellek_sec_o) n++;
    end
    bib_sec_i = 0;
    chk("timeout_sec_cycles", n, ZA);
    chk("timeout_hata", hata_o, 1);
    chk("timeout_ack_cnt", bib_ack_cnt, 1);
    chk("timeout_ack_veri", bib_ack_veri, 0);
    repeat (2) tick();
    chk("timeout_hata_sticky", hata_o, 1);

    // 5: owner withdraws mid-wait, pending fetch takes the next BOS
    bib_sec_i = 1; bib_adr_i = 32'h500;
    getir_sec_i = 1; getir_adr_i = 32'h600;
    exp_q.push_back(32'h500);
    exp_q.push_back(32'h600);
    wait_sec();
    repeat (2) tick();
    bib_sec_i = 0;
    tick();
    pulse(32'h1234_5678);
    chk("withdraw_bos", durum_o, HKM_BOS);
    chk("withdraw_getir_stalled", getir_durdur_o, 1);
    tick();
    chk("withdraw_getir_grant_sec", bellek_sec_o, 1);
    chk("withdraw_getir_grant_adr", bellek_adr_o, 32'h600);
    getir_ack_cnt = 0;
    serve(0, 32'h0BAD_F00D);
    getir_sec_i = 0;
    chk("withdraw_getir_ack", getir_ack_cnt, 1);
    chk("withdraw_getir_veri", getir_ack_veri, 32'h0BAD_F00D);
    tick();

    // 6: asynchronous reset while waiting on a load/store
    bib_sec_i = 1; bib_adr_i = 32'h700;
    exp_q.push_back(32'h700);
    wait_sec();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sec", bellek_sec_o, 0);
    chk("async_rst_durum", durum_o, HKM_BOS);
    chk("async_rst_hata", hata_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bib_adr_i = 32'h704;
    exp_q.push_back(32'h704);
    bib_ack_cnt = 0;
    serve(2, 32'h7777_0000);
    bib_sec_i = 0;
    chk("post_rst_ack", bib_ack_cnt, 1);
    chk("post_rst_veri", bib_ack_veri, 32'h7777_0000);
    repeat (3) tick();

    chk("grant_q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
